// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle RV32I controller and its
// datapath. The controller side is the master: it drives every control
// select and enable. The datapath side is the slave: it returns the
// instruction register, memory handshake and ALU flags.
interface multicycle_ctrl_if #(parameter int WORD_SIZE = 32);
  logic [31:0]          instr;
  logic                 mem_ready;
  logic                 alu_zero;
  logic [WORD_SIZE-1:0] alu_result;
  logic [3:0]           alu_op;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic                 pc_write;
  logic                 pc_sel;
  logic                 target_write;
  logic                 ir_write;
  logic                 mem_req;
  logic                 mem_we;
  logic                 mem_addr_sel;
  logic                 reg_write;
  logic [1:0]           wb_sel;
  logic                 trap;

  modport master (
    input  instr, mem_ready, alu_zero, alu_result,
    output alu_op, alu_src_a, alu_src_b, pc_write, pc_sel, target_write,
           ir_write, mem_req, mem_we, mem_addr_sel, reg_write, wb_sel, trap
  );

  modport slave (
    output instr, mem_ready, alu_zero, alu_result,
    input  alu_op, alu_src_a, alu_src_b, pc_write, pc_sel, target_write,
           ir_write, mem_req, mem_we, mem_addr_sel, reg_write, wb_sel, trap
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM. One instruction in flight; all outputs are
// combinational from state and instruction, and forced low while rst is high.
// Optional feature macro: MULTICYCLE_CTRL_TRAP_EN -- illegal instructions park
// the FSM in TRAP (trap=1) until reset. Without it they retire as NOPs.
//
// state  | meaning
// FETCH  | request instruction at PC, compute PC+4; on mem_ready load IR and PC
// DECODE | compute OLDPC+IMM into TARGET, classify opcode
// EXEC   | ALU operation / branch resolve / jump
// MEM    | load or store at ALU-out address, wait for mem_ready
// WB     | register-file write of ALU-out or memory data
// TRAP   | illegal instruction, held until reset (TRAP_EN builds only)
module multicycle_ctrl #(
  parameter int WORD_SIZE = 32
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_XOR = 4'd2, OP_SLL = 4'd3,
                         OP_SRL = 4'd4, OP_SRA = 4'd5, OP_ADD = 4'd6, OP_SUB = 4'd7,
                         OP_SLT = 4'd8, OP_SLTU = 4'd9;
  localparam logic [1:0] A_PC = 2'd0, A_OLDPC = 2'd1, A_RS1 = 2'd2, A_ZERO = 2'd3;
  localparam logic [1:0] B_RS2 = 2'd0, B_IMM = 2'd1, B_CONST4 = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0, WB_MEM = 2'd1, WB_LINK = 2'd2;
  localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_LD = 7'b0000011,
                         OPC_ST = 7'b0100011, OPC_BR = 7'b1100011, OPC_JAL = 7'b1101111,
                         OPC_JALR = 7'b1100111, OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111;

`ifdef MULTICYCLE_CTRL_TRAP_EN
  typedef enum logic [2:0] {
    ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2, ST_MEM = 3'd3, ST_WB = 3'd4, ST_TRAP = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2, ST_MEM = 3'd3, ST_WB = 3'd4
  } state_t;
`endif

  state_t      state, state_nxt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alt;
  logic        legal;
  logic        br_cond;
  logic        br_taken;
  logic        unused_bits;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign alt    = bus.instr[30];
  // Only bit 0 of the ALU result matters (SLT/SLTU branch outcome).
  assign unused_bits = ^{bus.alu_result[WORD_SIZE-1:1], bus.instr};

  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic sub_sra);
    case (f3)
      3'b000:  alu_map = sub_sra ? OP_SUB : OP_ADD;
      3'b001:  alu_map = OP_SLL;
      3'b010:  alu_map = OP_SLT;
      3'b011:  alu_map = OP_SLTU;
      3'b100:  alu_map = OP_XOR;
      3'b101:  alu_map = sub_sra ? OP_SRA : OP_SRL;
      3'b110:  alu_map = OP_OR;
      default: alu_map = OP_AND;
    endcase
  endfunction

  // Opcode legality; TRAP builds also reject R-type funct7 other than 0/0x20.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OPC_I, OPC_LD, OPC_ST, OPC_BR, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: legal = 1'b1;
`ifdef MULTICYCLE_CTRL_TRAP_EN
      OPC_R: legal = (bus.instr[31:25] == 7'h00) || (bus.instr[31:25] == 7'h20);
`else
      OPC_R: legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
  end

  // Branch outcome: BEQ/BNE on zero flag, the rest on result[0]; funct3[0] inverts.
  always_comb begin
    br_cond  = funct3[2] ? bus.alu_result[0] : bus.alu_zero;
    br_taken = (funct3[2:1] != 2'b01) && (br_cond ^ funct3[0]);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_nxt;
  end

  // Next-state and control outputs.
  always_comb begin
    state_nxt        = state;
    bus.alu_op       = OP_AND;
    bus.alu_src_a    = A_PC;
    bus.alu_src_b    = B_RS2;
    bus.pc_write     = 1'b0;
    bus.pc_sel       = 1'b0;
    bus.target_write = 1'b0;
    bus.ir_write     = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.reg_write    = 1'b0;
    bus.wb_sel       = WB_ALU;
    bus.trap         = 1'b0;
    if (rst) begin
      state_nxt = ST_FETCH;
    end else begin
      case (state)
        ST_FETCH: begin
          bus.mem_req   = 1'b1;
          bus.alu_op    = OP_ADD;
          bus.alu_src_a = A_PC;
          bus.alu_src_b = B_CONST4;
          if (bus.mem_ready) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            state_nxt    = ST_DECODE;
          end
        end
        ST_DECODE: begin
          bus.alu_op       = OP_ADD;
          bus.alu_src_a    = A_OLDPC;
          bus.alu_src_b    = B_IMM;
          bus.target_write = 1'b1;
`ifdef MULTICYCLE_CTRL_TRAP_EN
          state_nxt = legal ? ST_EXEC : ST_TRAP;
`else
          state_nxt = legal ? ST_EXEC : ST_FETCH;
`endif
        end
        ST_EXEC: begin
          state_nxt = ST_FETCH;
          case (opcode)
            OPC_R: begin
              bus.alu_op    = alu_map(funct3, alt);
              bus.alu_src_a = A_RS1;
              bus.alu_src_b = B_RS2;
              state_nxt     = ST_WB;
            end
            OPC_I: begin
              bus.alu_op    = alu_map(funct3, alt && (funct3 == 3'b101));
              bus.alu_src_a = A_RS1;
              bus.alu_src_b = B_IMM;
              state_nxt     = ST_WB;
            end
            OPC_LD, OPC_ST: begin
              bus.alu_op    = OP_ADD;
              bus.alu_src_a = A_RS1;
              bus.alu_src_b = B_IMM;
              state_nxt     = ST_MEM;
            end
            OPC_BR: begin
              bus.alu_op    = !funct3[2] ? OP_SUB : (funct3[1] ? OP_SLTU : OP_SLT);
              bus.alu_src_a = A_RS1;
              bus.alu_src_b = B_RS2;
              bus.pc_write  = br_taken;
              bus.pc_sel    = br_taken;
            end
            OPC_JAL: begin
              bus.pc_write  = 1'b1;
              bus.pc_sel    = 1'b1;
              bus.reg_write = 1'b1;
              bus.wb_sel    = WB_LINK;
            end
            OPC_JALR: begin
              bus.alu_op    = OP_ADD;
              bus.alu_src_a = A_RS1;
              bus.alu_src_b = B_IMM;
              bus.pc_write  = 1'b1;
              bus.reg_write = 1'b1;
              bus.wb_sel    = WB_LINK;
            end
            OPC_LUI: begin
              bus.alu_op    = OP_ADD;
              bus.alu_src_a = A_ZERO;
              bus.alu_src_b = B_IMM;
              state_nxt     = ST_WB;
            end
            OPC_AUIPC: begin
              bus.alu_op    = OP_ADD;
              bus.alu_src_a = A_OLDPC;
              bus.alu_src_b = B_IMM;
              state_nxt     = ST_WB;
            end
            default: state_nxt = ST_FETCH;
          endcase
        end
        ST_MEM: begin
          bus.mem_req      = 1'b1;
          bus.mem_addr_sel = 1'b1;
          bus.mem_we       = (opcode == OPC_ST);
          if (bus.mem_ready) state_nxt = (opcode == OPC_ST) ? ST_FETCH : ST_WB;
        end
        ST_WB: begin
          bus.reg_write = 1'b1;
          bus.wb_sel    = (opcode == OPC_LD) ? WB_MEM : WB_ALU;
          state_nxt     = ST_FETCH;
        end
`ifdef MULTICYCLE_CTRL_TRAP_EN
        ST_TRAP: begin
          bus.trap = 1'b1;
        end
`endif
        default: state_nxt = ST_FETCH;
      endcase
    end
  end

endmodule
